// File: rtl/cpu_pkg.sv
// Shared CPU-front-end definitions: fetch FSM states, default encodings and PC helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = '0;
    localparam logic [31:0] NOP_INSTR_DEFAULT = '0;
    localparam int unsigned PC_STEP_DEFAULT   = 4;

    // Sequential PC advance; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_advance(input logic [31:0] pc, input int unsigned step);
        return pc + step[31:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats freeze beats load; otherwise a bubble is inserted.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (flush) begin
            // if_pc deliberately keeps its value on a flush
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (hold) begin
            if_pc    <= if_pc;
            if_instr <= if_instr;
            if_valid <= if_valid;
        end else if (load) begin
            if_pc    <= load_pc;
            if_instr <= load_instr;
            if_valid <= 1'b1;
        end else begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM with hold buffer and branch drain, feeding IF/ID.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int unsigned PC_STEP   = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  drain_addr, drain_addr_nxt;
    logic [31:0]  hold_pc, hold_pc_nxt;
    logic [31:0]  hold_instr, hold_instr_nxt;
    logic [31:0]  seq_pc;
    logic         load;
    logic [31:0]  load_pc;
    logic [31:0]  load_instr;

    assign seq_pc = pc_advance(pc, PC_STEP);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        hold_pc_nxt    = hold_pc;
        hold_instr_nxt = hold_instr;
        imem_req       = 1'b0;
        imem_addr      = pc;
        load           = 1'b0;
        load_pc        = hold_pc;
        load_instr     = hold_instr;

        unique case (state)
            IDLE: begin
                state_nxt = REQ;
                if (br_taken) pc_nxt = br_addr;
            end
            REQ: begin
                imem_req = 1'b1;
                if (br_taken) begin
                    pc_nxt = br_addr;
                    // An outstanding request cannot be withdrawn: keep presenting it until acked.
                    if (!imem_ack) begin
                        drain_addr_nxt = pc;
                        state_nxt      = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_nxt = seq_pc;
                    if (freeze) begin
                        hold_pc_nxt    = seq_pc;
                        hold_instr_nxt = imem_rdata;
                        state_nxt      = HOLD;
                    end else begin
                        load       = 1'b1;
                        load_pc    = seq_pc;
                        load_instr = imem_rdata;
                    end
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_nxt    = br_addr;
                    state_nxt = REQ;
                end else if (!freeze) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (br_taken) pc_nxt = br_addr;
                if (imem_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_instr <= hold_instr_nxt;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (br_taken),
        .hold       (freeze),
        .load       (load),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_valid   (if_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage with a variable-latency instruction memory model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    if_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR),
        .PC_STEP   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Memory / program-order model state
    logic [31:0] model_pc = RESET_PC;
    int unsigned epoch    = 0;
    bit          busy     = 1'b0;
    int unsigned mem_lat  = 0;
    logic [31:0] mem_addr = '0;
    int unsigned mem_epoch = 0;
    bit          br_fired = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234} | 32'h1;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // One memory-side step, called right after a negedge.
    task automatic mem_step();
        imem_ack = 1'b0;
        if (busy) begin
            chk(imem_req == 1'b1, "req_held", {31'b0, imem_req}, 32'h1);
            chk(imem_addr == mem_addr, "addr_stable", imem_addr, mem_addr);
            if (mem_lat == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(mem_addr);
                busy       = 1'b0;
                if (mem_epoch == epoch) exp_q.push_back('{pc: mem_addr + 32'd4, instr: mem_word(mem_addr)});
            end else begin
                mem_lat--;
            end
        end else if (imem_req) begin
            chk(imem_addr == model_pc, "fetch_addr", imem_addr, model_pc);
            busy      = 1'b1;
            mem_addr  = imem_addr;
            mem_epoch = epoch;
            mem_lat   = $urandom_range(0, 2);
            model_pc  = model_pc + 32'd4;
        end
    endtask

    task automatic step(input bit f, input bit b, input logic [31:0] ba, input bit br_if_pending);
        @(negedge clk);
        mem_step();
        br_fired = 1'b0;
        if (br_if_pending && busy && mem_lat >= 1) begin
            b        = 1'b1;
            br_fired = 1'b1;
        end
        freeze   = f;
        br_taken = b;
        br_addr  = ba;
        if (b) begin
            epoch++;
            exp_q.delete();
            model_pc = ba;
        end
    endtask

    // IF/ID monitor: reference view of what decode should see after each edge.
    logic [31:0] cur_pc    = '0;
    logic [31:0] cur_instr = NOP_INSTR;
    logic        cur_valid = 1'b0;

    always begin
        bit   r, f, b;
        ent_t e;
        @(posedge clk);
        r = rst;
        f = freeze;
        b = br_taken;
        #1;
        if (r) begin
            cur_pc    = '0;
            cur_instr = NOP_INSTR;
            cur_valid = 1'b0;
        end else if (b) begin
            cur_instr = NOP_INSTR;
            cur_valid = 1'b0;
        end else if (f) begin
            cur_valid = cur_valid;
        end else if (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            cur_pc    = e.pc;
            cur_instr = e.instr;
            cur_valid = 1'b1;
        end else begin
            cur_instr = NOP_INSTR;
            cur_valid = 1'b0;
        end
        chk(if_valid == cur_valid, "if_valid", {31'b0, if_valid}, {31'b0, cur_valid});
        chk(if_instr == cur_instr, "if_instr", if_instr, cur_instr);
        chk(if_pc == cur_pc, "if_pc", if_pc, cur_pc);
    end

    initial begin
        logic [31:0] ba;
        int unsigned k;
        rst        = 1'b1;
        freeze     = 1'b0;
        br_taken   = 1'b0;
        br_addr    = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;

        repeat (3) @(negedge clk);
        chk(imem_req == 1'b0, "rst_req", {31'b0, imem_req}, 32'h0);
        chk(imem_addr == RESET_PC, "rst_addr", imem_addr, RESET_PC);
        rst = 1'b0;

        // Plain sequential stream
        repeat (20) step(1'b0, 1'b0, '0, 1'b0);

        // Randomized freeze / redirect traffic
        for (int i = 0; i < 1500; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      ba = 32'hFFFF_FFFC;
            else if (k == 1) ba = $urandom;
            else             ba = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 7, ba, 1'b0);
        end

        // PC wrap through 0xFFFF_FFFC
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (12) step(1'b0, 1'b0, '0, 1'b0);

        // Redirect while a request is outstanding, then reset in DRAIN
        k = 0;
        do begin
            step(1'b0, 1'b0, 32'h0000_0040, 1'b1);
            k++;
        end while (!br_fired && k < 50);
        chk(br_fired, "drain_setup", {31'b0, br_fired}, 32'h1);

        @(negedge clk);
        chk(imem_req == 1'b1, "drain_req", {31'b0, imem_req}, 32'h1);
        chk(imem_addr == mem_addr, "drain_addr", imem_addr, mem_addr);
        rst      = 1'b1;
        imem_ack = 1'b0;
        freeze   = 1'b0;
        br_taken = 1'b0;
        busy     = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        epoch++;

        @(negedge clk);
        rst = 1'b0;
        chk(imem_req == 1'b0, "post_rst_req", {31'b0, imem_req}, 32'h0);
        chk(imem_addr == RESET_PC, "post_rst_addr", imem_addr, RESET_PC);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;

        repeat (30) step(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
